// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared, variable-latency ALU.
// One command is in flight at a time; a missing ALU_VLD becomes a timeout response.
module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0,
  input  logic                    REQ1,
  input  logic [DATA_WIDTH-1:0]   A0,
  input  logic [DATA_WIDTH-1:0]   B0,
  input  logic [DATA_WIDTH-1:0]   A1,
  input  logic [DATA_WIDTH-1:0]   B1,
  input  logic [3:0]              FUNC0,
  input  logic [3:0]              FUNC1,
  output logic                    GNT0,
  output logic                    GNT1,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [3:0]              ALU_FUNC,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VLD0,
  output logic                    RSP_VLD1,
  output logic                    RSP_ERR,
  output logic                    BUSY
);

  localparam int               TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    last_q, last_d;
  logic                    gnt0_q, gnt0_d;
  logic                    gnt1_q, gnt1_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [3:0]              alu_func_q, alu_func_d;
  logic                    alu_en_q, alu_en_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_vld0_q, rsp_vld0_d;
  logic                    rsp_vld1_q, rsp_vld1_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic                    win;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    last_d     = last_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    alu_en_d   = alu_en_q;
    rsp_data_d = rsp_data_q;
    rsp_vld0_d = 1'b0;
    rsp_vld1_d = 1'b0;
    rsp_err_d  = rsp_err_q;
    win        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          // On contention the requester that was not served last wins.
          win        = (REQ0 && REQ1) ? ~last_q : REQ1;
          last_d     = win;
          gnt0_d     = ~win;
          gnt1_d     = win;
          alu_a_d    = win ? A1 : A0;
          alu_b_d    = win ? B1 : B0;
          alu_func_d = win ? FUNC1 : FUNC0;
          alu_en_d   = 1'b1;
          timer_d    = '0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // A result arriving on the last allowed cycle still counts as success.
        if (ALU_VLD) begin
          rsp_data_d = ALU_OUT;
          rsp_err_d  = 1'b0;
          alu_en_d   = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TMR_LIMIT) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          alu_en_d   = 1'b0;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_RESP: begin
        rsp_vld0_d = ~last_q;
        rsp_vld1_d = last_q;
        state_d    = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        alu_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      alu_en_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_vld0_q <= 1'b0;
      rsp_vld1_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      alu_en_q   <= alu_en_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld0_q <= rsp_vld0_d;
      rsp_vld1_q <= rsp_vld1_d;
      rsp_err_q  <= rsp_err_d;
      busy_q     <= busy_d;
    end
  end

  assign GNT0     = gnt0_q;
  assign GNT1     = gnt1_q;
  assign ALU_A    = alu_a_q;
  assign ALU_B    = alu_b_q;
  assign ALU_FUNC = alu_func_q;
  assign ALU_EN   = alu_en_q;
  assign RSP_DATA = rsp_data_q;
  assign RSP_VLD0 = rsp_vld0_q;
  assign RSP_VLD1 = rsp_vld1_q;
  assign RSP_ERR  = rsp_err_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized soak.
module tb_alu_arbiter;

  localparam int DW  = 8;
  localparam int TMO = 8;

  logic          clk;
  logic          rst;
  logic          req0, req1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic [3:0]    f0, f1;
  logic          gnt0, gnt1;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_func;
  logic          alu_en;
  logic [15:0]   alu_out;
  logic          alu_vld;
  logic [15:0]   rsp_data;
  logic          rsp_vld0, rsp_vld1, rsp_err, busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1),
    .A0(a0), .B0(b0), .A1(a1), .B1(b1), .FUNC0(f0), .FUNC1(f1),
    .GNT0(gnt0), .GNT1(gnt1), .ALU_A(alu_a), .ALU_B(alu_b),
    .ALU_FUNC(alu_func), .ALU_EN(alu_en), .ALU_OUT(alu_out), .ALU_VLD(alu_vld),
    .RSP_DATA(rsp_data), .RSP_VLD0(rsp_vld0), .RSP_VLD1(rsp_vld1),
    .RSP_ERR(rsp_err), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
    case (f)
      4'h0:    alu_fn = {8'h00, a} + {8'h00, b};
      4'h1:    alu_fn = {8'h00, a} - {8'h00, b};
      4'h2:    alu_fn = {8'h00, a} * {8'h00, b};
      default: alu_fn = {a ^ b, b + {4'h0, f}};
    endcase
  endfunction

  // ALU stand-in: asserts ALU_VLD when ALU_EN has been high for 'lat' sampled
  // cycles (lat=0: never). With 'noise' set it also raises stray VLD while disabled.
  int   lat   = 1;
  bit   noise = 1'b0;
  int   en_cnt = 0;
  always @(posedge clk) begin
    en_cnt <= alu_en ? en_cnt + 1 : 0;
    if (alu_en && lat != 0 && en_cnt + 1 == lat) begin
      alu_vld <= 1'b1;
      alu_out <= alu_fn(alu_a, alu_b, alu_func);
    end else begin
      alu_vld <= noise && !alu_en && ($urandom_range(3) == 0);
      alu_out <= 16'($urandom);
    end
  end

  // Reference model: tracks one transaction by its age in edges since the grant.
  bit          m_ready = 1'b0;
  bit          m_active, m_last, m_who;
  int          m_age, m_done;
  logic        e_gnt0, e_gnt1, e_en, e_vld0, e_vld1, e_err, e_busy;
  logic [7:0]  e_a, e_b;
  logic [3:0]  e_f;
  logic [15:0] e_data;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0; m_last = 1'b1; m_age = 0; m_done = 0; m_who = 1'b0;
      {e_gnt0, e_gnt1, e_en, e_vld0, e_vld1, e_err, e_busy} = '0;
      e_a = '0; e_b = '0; e_f = '0; e_data = '0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_vld0 = 1'b0; e_vld1 = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_done == 0) begin
          if (alu_vld) begin
            m_done = m_age; e_data = alu_out; e_err = 1'b0;
          end else if (m_age == TMO + 1) begin
            m_done = m_age; e_data = 16'h0000; e_err = 1'b1;
          end
        end else if (m_age == m_done + 1) begin
          if (m_who) e_vld1 = 1'b1; else e_vld0 = 1'b1;
          m_active = 1'b0;
        end
        e_en = m_active && (m_done == 0);
      end else if (req0 || req1) begin
        m_who  = (req0 && req1) ? !m_last : req1;
        m_last = m_who;
        e_gnt0 = !m_who; e_gnt1 = m_who;
        e_a = m_who ? a1 : a0; e_b = m_who ? b1 : b0; e_f = m_who ? f1 : f0;
        e_en = 1'b1; m_active = 1'b1; m_age = 0; m_done = 0;
      end
      e_busy = m_active;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      chk("gnt0", gnt0, e_gnt0);
      chk("gnt1", gnt1, e_gnt1);
      chk("alu_en", alu_en, e_en);
      chk("alu_a", alu_a, e_a);
      chk("alu_b", alu_b, e_b);
      chk("alu_func", alu_func, e_f);
      chk("rsp_data", rsp_data, e_data);
      chk("rsp_vld0", rsp_vld0, e_vld0);
      chk("rsp_vld1", rsp_vld1, e_vld1);
      chk("rsp_err", rsp_err, e_err);
      chk("busy", busy, e_busy);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1);
  end

  task automatic run_one(input bit who, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] f, output int r_lat, output int r_en,
                         output int r_gok, output int r_bad, output int r_rok,
                         output logic [15:0] r_data, output logic r_err);
    r_lat = 0; r_en = 0; r_gok = 0; r_bad = 0; r_rok = 0; r_data = 'x; r_err = 'x;
    if (who) begin a1 = a; b1 = b; f1 = f; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; f0 = f; req0 = 1'b1; end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (alu_en) r_en++;
      if ((who ? gnt1 : gnt0) === 1'b1) begin
        r_gok++;
        if (who) req1 = 1'b0; else req0 = 1'b0;
      end
      if ((who ? gnt0 : gnt1) === 1'b1 || (who ? rsp_vld0 : rsp_vld1) === 1'b1) r_bad++;
      if ((who ? rsp_vld1 : rsp_vld0) === 1'b1) begin
        if (r_rok == 0) begin r_lat = n; r_data = rsp_data; r_err = rsp_err; end
        r_rok++;
      end
      if (r_rok > 0 && n > r_lat) break;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic wait_quiet();
    bit ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (!busy && !alu_en && !req0 && !req1 && !rsp_vld0 && !rsp_vld1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("quiet_reached", ok, 1);
  endtask

  int          r_lat, r_en, r_gok, r_bad, r_rok;
  logic [15:0] r_data;
  logic        r_err;
  int          gq[$];
  int          rq[$];
  int          exp_rr[4] = '{0, 1, 0, 1};
  int          t_lat[4]  = '{0, 8, 9, 1};
  bit          t_err[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  int          t_en[4]   = '{9, 9, 9, 2};
  int          t_rsp[4]  = '{11, 11, 11, 4};
  int          lat_tab[8] = '{0, 1, 1, 2, 3, 5, 8, 9};
  int          ng;
  bit          done, rer, seen;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; f0 = '0; f1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_alu_en", alu_en, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_alu_a", alu_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // single request, nominal ALU
    lat = 1;
    run_one(1'b0, 8'h05, 8'h03, 4'h0, r_lat, r_en, r_gok, r_bad, r_rok, r_data, r_err);
    chk("single_latency", r_lat, 4);
    chk("single_gnt_pulses", r_gok, 1);
    chk("single_rsp_pulses", r_rok, 1);
    chk("single_wrong_side", r_bad, 0);
    chk("single_rsp_data", r_data, 16'h0008);
    chk("single_rsp_err", r_err, 0);
    chk("single_en_cycles", r_en, 2);
    chk("model_single_data", e_data, 16'h0008);

    // timeout boundary table: never / 8th WAIT cycle / one late / nominal
    for (int i = 0; i < 4; i++) begin
      lat = t_lat[i];
      run_one(1'b0, 8'h21, 8'h10, 4'h0, r_lat, r_en, r_gok, r_bad, r_rok, r_data, r_err);
      chk($sformatf("tmo%0d_en_cycles", i), r_en, t_en[i]);
      chk($sformatf("tmo%0d_latency", i), r_lat, t_rsp[i]);
      chk($sformatf("tmo%0d_rsp_err", i), r_err, t_err[i]);
      chk($sformatf("tmo%0d_rsp_data", i), r_data, t_err[i] ? 32'h0 : 32'h31);
      chk($sformatf("tmo%0d_rsp_pulses", i), r_rok, 1);
      chk($sformatf("model_tmo%0d_err", i), e_err, t_err[i]);
    end

    // round-robin with both requesters held from reset
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    lat = 1;
    a0 = 8'h01; b0 = 8'h02; a1 = 8'h03; b1 = 8'h04; req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 80 && rq.size() < 4; n++) begin
      @(negedge clk);
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
      if (rsp_vld0) rq.push_back(0);
      if (rsp_vld1) rq.push_back(1);
      if (gq.size() >= 4) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("rr_grant_count", gq.size(), 4);
    chk("rr_rsp_count", rq.size(), 4);
    while (gq.size() < 4) gq.push_back(9);
    while (rq.size() < 4) rq.push_back(9);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant_%0d", i), gq[i], exp_rr[i]);
      chk($sformatf("rr_rsp_%0d", i), rq[i], exp_rr[i]);
    end
    wait_quiet();

    // reset while waiting on the ALU
    lat = 0; a1 = 8'h5A; b1 = 8'hA5; f1 = 4'h1; req1 = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (gnt1) begin seen = 1'b1; req1 = 1'b0; end
    end
    chk("abort_granted", seen, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lat = 1;
    chk("abort_busy", busy, 0);
    chk("abort_alu_en", alu_en, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_rsp_vld", {rsp_vld0, rsp_vld1}, 0);
    chk("abort_gnt", {gnt0, gnt1}, 0);
    chk("abort_rsp_data_err", {rsp_data, rsp_err}, 0);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("abort_regrant_gnt0", gnt0, 1);
    chk("abort_regrant_gnt1", gnt1, 0);
    req0 = 1'b0;
    wait_quiet();

    // new REQ1 and operands while a REQ1 command is in flight
    lat = 4; a1 = 8'h11; b1 = 8'h22; f1 = 4'h3; req1 = 1'b1;
    ng = 0; done = 1'b0; rer = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (gnt1) begin
        ng++; req1 = 1'b0;
        if (ng == 2) begin
          chk("req1_new_alu_a", alu_a, 8'h77);
          chk("req1_new_alu_b", alu_b, 8'h66);
          chk("req1_new_alu_func", alu_func, 4'h5);
          done = 1'b1;
        end
      end else if (ng == 1) begin
        chk("req1_hold_alu_a", alu_a, 8'h11);
        chk("req1_hold_alu_b", alu_b, 8'h22);
        chk("req1_hold_alu_func", alu_func, 4'h3);
        if (!rer) begin
          req1 = 1'b1; a1 = 8'h77; b1 = 8'h66; f1 = 4'h5; rer = 1'b1;
        end
      end
    end
    chk("req1_grants", ng, 2);
    wait_quiet();

    // randomized soak with stray ALU_VLD and occasional reset
    noise = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(399) == 0) rst = 1'b1;
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (!req0) begin
        a0 = 8'($urandom); b0 = 8'($urandom); f0 = 4'($urandom);
        if ($urandom_range(2) == 0) req0 = 1'b1;
      end
      if (!req1) begin
        a1 = 8'($urandom); b1 = 8'($urandom); f1 = 4'($urandom);
        if ($urandom_range(2) == 0) req1 = 1'b1;
      end
      if ($urandom_range(15) == 0) lat = lat_tab[$urandom_range(7)];
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; noise = 1'b0; lat = 1;
    wait_quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
